// File: rtl/lcd_phy.sv
// 4-bit HD44780-style LCD physical layer: power-on nibble init, then byte writes
// as two timed nibbles, with a done pulse once the LCD can take the next byte.
module lcd_phy #(
  parameter int T_SETUP    = 2,
  parameter int T_E_HIGH   = 12,
  parameter int T_HOLD     = 1,
  parameter int T_NIB_GAP  = 50,
  parameter int T_CMD_WAIT = 2000,
  parameter int T_PWR_ON   = 750000,
  parameter int T_INIT1    = 205000,
  parameter int T_INIT2    = 5000,
  parameter int T_INIT3    = 2000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       do_init,
  input  logic       do_send_data,
  input  logic [7:0] data_to_send,
  input  logic       lcdrs_in,
  output logic       init_done,
  output logic       lcde,
  output logic       lcdrs,
  output logic       lcdrw,
  output logic [3:0] lcddat,
  output logic       send_data_done
);

  typedef enum logic [3:0] {
    UNINIT, PWR_WAIT, INIT_NIB, INIT_WAIT, READY,
    NIB_HI, NIB_GAP, NIB_LO, CMD_WAIT, DONE
  } state_t;

  localparam int NIB_LEN = T_SETUP + T_E_HIGH + T_HOLD;

  localparam logic [CNT_W-1:0] L_NIB   = CNT_W'(NIB_LEN - 1);
  localparam logic [CNT_W-1:0] L_PWR   = CNT_W'(T_PWR_ON - 1);
  localparam logic [CNT_W-1:0] L_INIT1 = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] L_INIT2 = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] L_INIT3 = CNT_W'(T_INIT3 - 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(T_NIB_GAP - 1);
  localparam logic [CNT_W-1:0] L_CMD   = CNT_W'(T_CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] E_LO    = CNT_W'(T_HOLD);
  localparam logic [CNT_W-1:0] E_HI    = CNT_W'(T_HOLD + T_E_HIGH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_load_val;
  logic             w_load;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_byte;
  logic             r_rs;
  logic             w_latch;

  logic             r_lcde, r_lcdrs, r_done, r_init_done;
  logic [3:0]       r_lcddat;
  logic             w_lcde, w_rs, w_done, w_init_done;
  logic [3:0]       w_dat;

  logic             w_cnt_zero;
  logic             w_nib_state;
  logic             w_e_win;
  logic [CNT_W-1:0] w_init_wait;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_nib_state = (r_state == INIT_NIB) || (r_state == NIB_HI) || (r_state == NIB_LO);
  // Counter runs NIB_LEN-1 down to 0: setup at the top, E window in the middle, hold at the bottom.
  assign w_e_win     = (r_cnt >= E_LO) && (r_cnt < E_HI);

  always_comb begin
    case (r_idx)
      2'd0:    w_init_wait = L_INIT1;
      2'd1:    w_init_wait = L_INIT2;
      default: w_init_wait = L_INIT3;
    endcase
  end

  // Next state, counter reload and next values of the registered pins.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_lcde      = w_nib_state && w_e_win;
    w_dat       = r_lcddat;
    w_rs        = r_lcdrs;
    w_done      = 1'b0;
    w_init_done = r_init_done;

    case (r_state)
      UNINIT: begin
        if (do_init) begin
          w_state_nxt = PWR_WAIT;
          w_load      = 1'b1;
          w_load_val  = L_PWR;
          w_idx_nxt   = 2'd0;
        end
      end
      PWR_WAIT: begin
        w_rs = 1'b0;
        if (w_cnt_zero) begin
          w_state_nxt = INIT_NIB;
          w_load      = 1'b1;
          w_load_val  = L_NIB;
        end
      end
      INIT_NIB: begin
        w_rs  = 1'b0;
        w_dat = (r_idx == 2'd3) ? 4'h2 : 4'h3;
        if (w_cnt_zero) begin
          w_state_nxt = INIT_WAIT;
          w_load      = 1'b1;
          w_load_val  = w_init_wait;
        end
      end
      INIT_WAIT: begin
        w_rs = 1'b0;
        if (w_cnt_zero) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = READY;
            w_init_done = 1'b1;
          end else begin
            w_state_nxt = INIT_NIB;
            w_load      = 1'b1;
            w_load_val  = L_NIB;
            w_idx_nxt   = r_idx + 2'd1;
          end
        end
      end
      READY: begin
        if (do_send_data) begin
          w_state_nxt = NIB_HI;
          w_load      = 1'b1;
          w_load_val  = L_NIB;
          w_latch     = 1'b1;
        end
      end
      NIB_HI: begin
        w_rs  = r_rs;
        w_dat = r_byte[7:4];
        if (w_cnt_zero) begin
          w_state_nxt = NIB_GAP;
          w_load      = 1'b1;
          w_load_val  = L_GAP;
        end
      end
      NIB_GAP: begin
        w_rs = r_rs;
        if (w_cnt_zero) begin
          w_state_nxt = NIB_LO;
          w_load      = 1'b1;
          w_load_val  = L_NIB;
        end
      end
      NIB_LO: begin
        w_rs  = r_rs;
        w_dat = r_byte[3:0];
        if (w_cnt_zero) begin
          w_state_nxt = CMD_WAIT;
          w_load      = 1'b1;
          w_load_val  = L_CMD;
        end
      end
      CMD_WAIT: begin
        w_rs = r_rs;
        if (w_cnt_zero) w_state_nxt = DONE;
      end
      DONE: begin
        w_rs        = r_rs;
        w_done      = 1'b1;
        w_state_nxt = READY;
      end
      default: w_state_nxt = UNINIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= UNINIT;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_byte      <= 8'h00;
      r_rs        <= 1'b0;
      r_lcde      <= 1'b0;
      r_lcdrs     <= 1'b0;
      r_lcddat    <= 4'h0;
      r_done      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load)           r_cnt <= w_load_val;
      else if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
      if (w_latch) begin
        r_byte <= data_to_send;
        r_rs   <= lcdrs_in;
      end
      r_lcde      <= w_lcde;
      r_lcdrs     <= w_rs;
      r_lcddat    <= w_dat;
      r_done      <= w_done;
      r_init_done <= w_init_done;
    end
  end

  assign lcde           = r_lcde;
  assign lcdrs          = r_lcdrs;
  assign lcdrw          = 1'b0;
  assign lcddat         = r_lcddat;
  assign send_data_done = r_done;
  assign init_done      = r_init_done;

endmodule

// File: tb/tb_lcd_phy.sv
// Scoreboard bench for lcd_phy: driver pushes expected nibbles/done/init_done
// events computed from the timing rules; a negedge monitor pops and compares.
module tb_lcd_phy;
  localparam int T_SETUP = 2, T_E_HIGH = 12, T_HOLD = 1, T_NIB_GAP = 5, T_CMD_WAIT = 7;
  localparam int T_PWR_ON = 20, T_INIT1 = 10, T_INIT2 = 8, T_INIT3 = 6;
  localparam int NIB = T_SETUP + T_E_HIGH + T_HOLD;

  logic       clk = 1'b0, reset = 1'b1, do_init = 1'b0, do_send_data = 1'b0, lcdrs_in = 1'b0;
  logic [7:0] data_to_send = 8'h00;
  logic       init_done, lcde, lcdrs, lcdrw, send_data_done;
  logic [3:0] lcddat;

  lcd_phy #(
    .T_SETUP(T_SETUP), .T_E_HIGH(T_E_HIGH), .T_HOLD(T_HOLD), .T_NIB_GAP(T_NIB_GAP),
    .T_CMD_WAIT(T_CMD_WAIT), .T_PWR_ON(T_PWR_ON), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .T_INIT3(T_INIT3), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .do_init(do_init), .do_send_data(do_send_data),
    .data_to_send(data_to_send), .lcdrs_in(lcdrs_in), .init_done(init_done), .lcde(lcde),
    .lcdrs(lcdrs), .lcdrw(lcdrw), .lcddat(lcddat), .send_data_done(send_data_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] dat; logic rs; int cyc; } nib_t;
  nib_t nib_q[$];
  int   done_q[$];
  int   idone_q[$];

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timing: a phase entered on edge P lasts its T cycles; pins show the
  // phase one cycle later, so E rises T_SETUP+1 edges after a nibble phase begins.
  function automatic void push_init(input int i_edge);
    int p;
    int waits[4];
    logic [3:0] dats[4];
    nib_t n;
    waits = '{T_INIT1, T_INIT2, T_INIT3, T_INIT3};
    dats  = '{4'h3, 4'h3, 4'h3, 4'h2};
    p = i_edge + T_PWR_ON;
    for (int k = 0; k < 4; k++) begin
      n.dat = dats[k]; n.rs = 1'b0; n.cyc = p + T_SETUP + 1;
      nib_q.push_back(n);
      p += NIB + waits[k];
    end
    idone_q.push_back(p);
  endfunction

  function automatic void push_send(input int a, input logic [7:0] b, input logic rs);
    nib_t n;
    n.dat = b[7:4]; n.rs = rs; n.cyc = a + T_SETUP + 1;
    nib_q.push_back(n);
    n.dat = b[3:0]; n.rs = rs; n.cyc = a + NIB + T_NIB_GAP + T_SETUP + 1;
    nib_q.push_back(n);
    done_q.push_back(a + 2*NIB + T_NIB_GAP + T_CMD_WAIT + 1);
  endfunction

  // Monitor
  logic       mon_en = 1'b0, in_init = 1'b0;
  logic       prev_e = 1'b0, prev_done = 1'b0, prev_idone = 1'b0;
  logic [3:0] e_dat = 4'h0;
  int         e_w = 0, rw_bad = 0, rs_init_bad = 0;
  nib_t       mn;

  always @(negedge clk) begin
    if (mon_en) begin
      if (lcdrw !== 1'b0) rw_bad++;
      if (in_init && lcdrs !== 1'b0) rs_init_bad++;
      if (lcde === 1'b1 && !prev_e) begin
        chk("nibble_expected", nib_q.size() > 0, 1);
        if (nib_q.size() > 0) begin
          mn = nib_q.pop_front();
          chk("nib_dat", lcddat, mn.dat);
          chk("nib_rs", lcdrs, mn.rs);
          chk("e_rise_cycle", cyc, mn.cyc);
        end
        e_w = 1; e_dat = lcddat;
      end else if (lcde === 1'b1) e_w++;
      if (lcde === 1'b0 && prev_e) begin
        chk("e_width", e_w, T_E_HIGH);
        chk("dat_held_after_e", lcddat, e_dat);
      end
      if (send_data_done === 1'b1) begin
        chk("done_one_cycle", prev_done, 0);
        if (!prev_done) begin
          chk("done_expected", done_q.size() > 0, 1);
          if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
        end
      end
      if (init_done === 1'b1 && !prev_idone) begin
        chk("init_done_expected", idone_q.size() > 0, 1);
        if (idone_q.size() > 0) chk("init_done_cycle", cyc, idone_q.pop_front());
      end
      prev_e     = (lcde === 1'b1);
      prev_done  = (send_data_done === 1'b1);
      prev_idone = (init_done === 1'b1);
    end
  end

  // Driver
  task automatic wait_init();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) break;
    end
    chk("init_done_seen", init_done, 1);
    in_init = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (send_data_done === 1'b1) break;
    end
    chk("done_seen", send_data_done, 1);
  endtask

  task automatic run_init();
    int i_edge;
    do_init = 1'b1;
    @(posedge clk); #1;
    i_edge = cyc;
    push_init(i_edge);
    in_init = 1'b1;
    @(negedge clk);
    do_init = 1'b1;       // still high inside PWR_WAIT: must be ignored
    do_send_data = 1'b0;
    @(negedge clk);
    do_init = 1'b0;
    wait_init();
  endtask

  task automatic send(input logic [7:0] b, input logic rs, input int gap, input logic mutate);
    int a;
    repeat (gap) @(negedge clk);
    data_to_send = b; lcdrs_in = rs; do_send_data = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    push_send(a, b, rs);
    do_send_data = 1'b0;
    if (mutate) begin
      data_to_send = ~b; lcdrs_in = ~rs;
    end
    wait_done();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    // 1. reset and pre-init send request
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_lcde", lcde, 0);
    chk("rst_lcdrs", lcdrs, 0);
    chk("rst_lcdrw", lcdrw, 0);
    chk("rst_lcddat", lcddat, 0);
    chk("rst_done", send_data_done, 0);
    @(negedge clk);
    reset = 1'b0; mon_en = 1'b1;
    data_to_send = 8'hAA; lcdrs_in = 1'b1; do_send_data = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_done_before_init", send_data_done, 0);

    // 2. init, with do_send_data still high on the starting edge
    run_init();

    // 3. single data byte
    send(8'h48, 1'b1, 1, 1'b0);

    // 4. back-to-back with do_send_data held
    repeat (2) @(negedge clk);
    data_to_send = 8'h01; lcdrs_in = 1'b0; do_send_data = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    push_send(a, 8'h01, 1'b0);
    wait_done();
    data_to_send = 8'h80;
    @(posedge clk); #1;
    a = cyc;
    push_send(a, 8'h80, 1'b0);
    do_send_data = 1'b0;
    wait_done();
    repeat (30) @(negedge clk);

    // 6. data changed mid-byte, plus random traffic
    send(8'h5A, 1'b0, 0, 1'b1);
    for (int k = 0; k < 10; k++)
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // 5. reset inside the gap between nibbles
    @(negedge clk);
    data_to_send = 8'h3C; lcdrs_in = 1'b1; do_send_data = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    push_send(a, 8'h3C, 1'b1);
    do_send_data = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    nib_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    chk("midbyte_rst_lcde", lcde, 0);
    chk("midbyte_rst_init_done", init_done, 0);
    chk("midbyte_rst_done", send_data_done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_init_without_do_init", init_done, 0);
    run_init();
    send(8'hC3, 1'b1, 2, 1'b1);

    repeat (20) @(negedge clk);
    chk("nib_q_drained", nib_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("idone_q_drained", idone_q.size(), 0);
    chk("lcdrw_always_0", rw_bad, 0);
    chk("lcdrs_0_in_init", rs_init_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
